// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings and helpers for the multi-port memory arbiter
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  function automatic logic is_io(input logic [31:0] a);
    return a[17:16] == 2'b11;
  endfunction

  // Size code 11 falls through to a full word
  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    return s == SZ_BYTE ? 3'd1 : s == SZ_HALF ? 3'd2 : 3'd4;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] n, input logic s);
    return n == 3'd1 ? {{24{s & d[7]}}, d[7:0]} : n == 3'd2 ? {{16{s & d[15]}}, d[15:0]} : d;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant over a request vector, round-robin or fixed priority
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ARB_MODE  = 0,
  localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] valid_i,
  input  logic [IW-1:0]        ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IW-1:0]        idx_o
);
  int p;
  // Scan from lowest to highest priority so the highest-priority requester is the last hit kept
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    p = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      p = ARB_MODE != 0 ? k : (int'(ptr_i) + 1 + k) % NUM_PORTS;
      if (|(valid_i & (NUM_PORTS'(1) << p))) begin
        gnt_o = NUM_PORTS'(1) << p;
        idx_o = IW'(p);
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates requesters onto the byte-serial RAM/IO bus
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ARB_MODE  = 0,
  localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  input  logic                    flush_in,
  input  logic [NUM_PORTS-1:0]    req_valid,
  input  logic [NUM_PORTS-1:0]    req_wr,
  input  logic [2*NUM_PORTS-1:0]  req_size,
  input  logic [NUM_PORTS-1:0]    req_signed,
  input  logic [32*NUM_PORTS-1:0] req_addr,
  input  logic [32*NUM_PORTS-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]    resp_done,
  output logic [31:0]             resp_data
);
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, g_idx;
  logic [NUM_PORTS-1:0] gnt, done_q, done_d;
  logic [2:0] cnt_q, cnt_d, n_q, n_d;
  logic [31:0] wdata_q, wdata_d, data_q, data_d, a_q, a_d, rdata_q, rdata_d, nxt_a, g_addr, g_wdata;
  logic [7:0] dout_q, dout_d, din_q, din;
  logic sgn_q, sgn_d, mwr_q, mwr_d, rdy_q, g_wr, g_sgn;
  logic [1:0] g_size;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS), .ARB_MODE(ARB_MODE)) u_arb (
    .valid_i(req_valid),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt),
    .idx_o  (g_idx)
  );

  assign g_addr  = 32'(req_addr >> (32 * g_idx));
  assign g_wdata = 32'(req_wdata >> (32 * g_idx));
  assign g_size  = 2'(req_size >> {g_idx, 1'b0});
  assign g_wr    = 1'(req_wr >> g_idx);
  assign g_sgn   = 1'(req_signed >> g_idx);
  assign nxt_a   = a_q + 32'd1;
  assign din     = rdy_q ? mem_din : din_q;

  assign mem_a     = a_q;
  assign mem_dout  = dout_q;
  assign mem_wr    = mwr_q & rdy_in;
  assign resp_done = done_q;
  assign resp_data = rdata_q;

  // Keep the bus byte seen just before a freeze, since the RAM keeps answering the held address
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      rdy_q <= 1'b1;
      din_q <= '0;
    end else begin
      rdy_q <= rdy_in;
      din_q <= din;
    end

  // Grant, byte sequencing, IO stall and flush handling
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    dout_d  = dout_q;
    a_d     = '0;
    mwr_d   = 1'b0;
    done_d  = '0;
    case (state_q)
      IDLE: if (|gnt) begin
        state_d = g_wr ? WR : RD;
        ptr_d   = ARB_MODE != 0 ? ptr_q : g_idx;
        idx_d   = g_idx;
        cnt_d   = '0;
        n_d     = size_bytes(g_size);
        sgn_d   = g_sgn;
        wdata_d = g_wdata;
        data_d  = '0;
        a_d     = g_addr;
        dout_d  = g_wr ? g_wdata[7:0] : dout_q;
        mwr_d   = g_wr && !(is_io(g_addr) && io_buffer_full);
      end
      RD: if (!flush_in) begin
        data_d  = cnt_q == 3'd0 ? data_q : data_q | (32'(din) << {cnt_q - 3'd1, 3'b000});
        state_d = cnt_q == n_q ? DONE : RD;
        done_d  = cnt_q == n_q ? NUM_PORTS'(1) << idx_q : '0;
        rdata_d = cnt_q == n_q ? extend(data_d, n_q, sgn_q) : rdata_q;
        cnt_d   = cnt_q + 3'd1;
        a_d     = cnt_q + 3'd1 < n_q ? nxt_a : '0;
      end else begin
        state_d = IDLE;
      end
      WR: if (!mwr_q) begin
        a_d   = a_q;
        mwr_d = !(is_io(a_q) && io_buffer_full);
      end else if (cnt_q + 3'd1 == n_q) begin
        state_d = DONE;
        done_d  = NUM_PORTS'(1) << idx_q;
      end else begin
        cnt_d  = cnt_q + 3'd1;
        a_d    = nxt_a;
        dout_d = 8'(wdata_q >> {cnt_d, 3'b000});
        mwr_d  = !(is_io(nxt_a) && io_buffer_full);
      end
      DONE: state_d = IDLE;
    endcase
  end

  // State and registered outputs; rdy_in low freezes everything
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_PORTS - 1);
      idx_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      dout_q  <= '0;
      a_q     <= '0;
      mwr_q   <= 1'b0;
      done_q  <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      dout_q  <= dout_d;
      a_q     <= a_d;
      mwr_q   <= mwr_d;
      done_q  <= done_d;
    end
endmodule
